// File: rtl/pq_rd_driver_if.sv
// ---------------------------------------------------------------------------
// pq_rd_driver_if
//   Bundles the command/response port of the PQ read/replace driver together
//   with the signals the driver exchanges with the priority-queue instance.
//
//   Command side : cmd_valid, cmd_ready, cmd_op[1:0], cmd_kv[KV_W-1:0]
//   Response side: rsp_valid, rsp_kv[KV_W-1:0], rsp_err[1:0]
//   PQ side      : pq_rst, pq_kvi, pq_replace, pq_deq (to the PQ)
//                  pq_full, pq_busy, pq_empty, pq_kvo (from the PQ)
//
//   Modports:
//     slave  - the driver itself (accepts commands, drives the PQ strobes)
//     master - the environment around it (sequencer issuing commands and the
//              PQ instance answering with its status/head signals)
// ---------------------------------------------------------------------------
interface pq_rd_driver_if #(
    parameter int KV_W = 16
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [KV_W-1:0] cmd_kv;

    logic            rsp_valid;
    logic [KV_W-1:0] rsp_kv;
    logic [1:0]      rsp_err;

    logic            pq_rst;
    logic [KV_W-1:0] pq_kvi;
    logic            pq_replace;
    logic            pq_deq;
    logic            pq_full;
    logic            pq_busy;
    logic            pq_empty;
    logic [KV_W-1:0] pq_kvo;

    modport slave (
        input  cmd_valid, cmd_op, cmd_kv,
        output cmd_ready,
        output rsp_valid, rsp_kv, rsp_err,
        output pq_rst, pq_kvi, pq_replace, pq_deq,
        input  pq_full, pq_busy, pq_empty, pq_kvo
    );

    modport master (
        output cmd_valid, cmd_op, cmd_kv,
        input  cmd_ready,
        input  rsp_valid, rsp_kv, rsp_err,
        input  pq_rst, pq_kvi, pq_replace, pq_deq,
        output pq_full, pq_busy, pq_empty, pq_kvo
    );
endinterface

// File: rtl/pq_rd_driver.sv
// ---------------------------------------------------------------------------
// pq_rd_driver
//   Initiator-side controller for the priority-queue read/replace interface.
//   Accepts one command at a time (PEEK / DEQ / REPLACE), issues it to the PQ
//   as a single-cycle strobe, waits for the PQ to go idle again and reports
//   the head value seen before the operation plus an error code.
//
//   Parameters:
//     KV_W     - key/value width
//     MIN_WAIT - cycles after the strobe before pq_busy is trusted (1..15)
//     TIMEOUT  - max busy cycles tolerated per wait phase (1..65535)
//
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-high reset (also forwarded as pq_rst)
//     bus  - pq_rd_driver_if.slave: command, response and PQ signals
//
//   Optional build macro PQ_DRV_STATS_EN adds:
//     stat_ops     - completed ok operations (saturating)
//     stat_errs    - error responses (saturating)
//     stat_maxwait - largest busy-wait cycle count of any single operation
// ---------------------------------------------------------------------------
module pq_rd_driver #(
    parameter int KV_W     = 16,
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    pq_rd_driver_if.slave    bus
`ifdef PQ_DRV_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_errs,
    output logic [15:0]      stat_maxwait
`endif
);

    localparam logic [1:0] OP_PEEK   = 2'b00;
    localparam logic [1:0] OP_DEQ    = 2'b01;
    localparam logic [1:0] OP_REPL   = 2'b10;
    localparam logic [1:0] OP_BAD    = 2'b11;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_EMPTY = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_BADOP = 2'b11;

    // Counters run from 0 up to these terminal values and stop there, so they
    // can never wrap.
    localparam logic [3:0]  MIN_LAST = 4'(MIN_WAIT - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT_RDY,
        S_ISSUE,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [KV_W-1:0] kv_q, kv_d;
    logic [KV_W-1:0] snap_q, snap_d;
    logic [3:0]      wait_q, wait_d;
    logic [15:0]     tmo_q, tmo_d;

    logic            cmd_ready_q;
    logic            rsp_valid_q;
    logic [KV_W-1:0] rsp_kv_q, rsp_kv_d;
    logic [1:0]      rsp_err_q, rsp_err_d;
    logic [KV_W-1:0] pq_kvi_q, pq_kvi_d;
    logic            pq_replace_q;
    logic            pq_deq_q;

    // REPLACE is legal on a full queue, so the full flag never gates anything.
    logic            unused_full;
    assign unused_full = bus.pq_full;

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        kv_d      = kv_q;
        snap_d    = snap_q;
        wait_d    = wait_q;
        tmo_d     = tmo_q;
        rsp_kv_d  = rsp_kv_q;
        rsp_err_d = rsp_err_q;
        pq_kvi_d  = pq_kvi_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d    = bus.cmd_op;
                    kv_d    = bus.cmd_kv;
                    wait_d  = 4'd0;
                    tmo_d   = 16'd0;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (op_q == OP_BAD) begin
                    rsp_err_d = ERR_BADOP;
                    rsp_kv_d  = bus.pq_kvo;
                    state_d   = S_RESP;
                end else if (op_q == OP_DEQ && bus.pq_empty) begin
                    rsp_err_d = ERR_EMPTY;
                    rsp_kv_d  = bus.pq_kvo;
                    state_d   = S_RESP;
                end else if (bus.pq_busy) begin
                    state_d = S_WAIT_RDY;
                end else begin
                    state_d = S_ISSUE;
                end
            end

            S_WAIT_RDY: begin
                if (bus.pq_busy) begin
                    if (tmo_q == TMO_LAST) begin
                        rsp_err_d = ERR_TMO;
                        rsp_kv_d  = bus.pq_kvo;
                        state_d   = S_RESP;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end else if (op_q == OP_DEQ && bus.pq_empty) begin
                    // The queue may have drained while we were waiting.
                    rsp_err_d = ERR_EMPTY;
                    rsp_kv_d  = bus.pq_kvo;
                    state_d   = S_RESP;
                end else begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Head before the operation; the strobe is high this cycle.
                snap_d = bus.pq_kvo;
                wait_d = 4'd0;
                tmo_d  = 16'd0;
                if (op_q == OP_PEEK) begin
                    rsp_kv_d  = bus.pq_kvo;
                    rsp_err_d = ERR_OK;
                    state_d   = S_RESP;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                if (wait_q != MIN_LAST) begin
                    wait_d = wait_q + 4'd1;
                end else if (!bus.pq_busy) begin
                    rsp_kv_d  = snap_q;
                    rsp_err_d = ERR_OK;
                    state_d   = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_kv_d  = snap_q;
                    rsp_err_d = ERR_TMO;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The write value is presented together with the replace strobe and
        // then left on the bus until the next REPLACE.
        if (state_d == S_ISSUE && op_q == OP_REPL) begin
            pq_kvi_d = kv_q;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers. Strobes, ready and valid are decoded from
    // the next state so they are glitch-free registered outputs that line up
    // exactly with the ISSUE / IDLE / RESP cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 2'b00;
            kv_q         <= '0;
            snap_q       <= '0;
            wait_q       <= 4'd0;
            tmo_q        <= 16'd0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_kv_q     <= '0;
            rsp_err_q    <= 2'b00;
            pq_kvi_q     <= '0;
            pq_replace_q <= 1'b0;
            pq_deq_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            kv_q         <= kv_d;
            snap_q       <= snap_d;
            wait_q       <= wait_d;
            tmo_q        <= tmo_d;
            cmd_ready_q  <= (state_d == S_IDLE);
            rsp_valid_q  <= (state_d == S_RESP);
            rsp_kv_q     <= rsp_kv_d;
            rsp_err_q    <= rsp_err_d;
            pq_kvi_q     <= pq_kvi_d;
            pq_replace_q <= (state_d == S_ISSUE) && (op_q == OP_REPL);
            pq_deq_q     <= (state_d == S_ISSUE) && (op_q == OP_DEQ);
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_kv     = rsp_kv_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.pq_rst     = rst;
    assign bus.pq_kvi     = pq_kvi_q;
    assign bus.pq_replace = pq_replace_q;
    assign bus.pq_deq     = pq_deq_q;

`ifdef PQ_DRV_STATS_EN
    // ------------------------------------------------------------------
    // Statistics. busy_tot_q sums the busy cycles of both wait phases of the
    // current operation and is folded into the counters in the RESP cycle.
    // ------------------------------------------------------------------
    logic [15:0] stat_ops_q;
    logic [15:0] stat_errs_q;
    logic [15:0] stat_maxwait_q;
    logic [15:0] busy_tot_q;
    logic        busy_tick;

    always_comb begin
        busy_tick = 1'b0;
        if (state_q == S_WAIT_RDY && bus.pq_busy) begin
            busy_tick = 1'b1;
        end
        if (state_q == S_WAIT_DONE && wait_q == MIN_LAST && bus.pq_busy) begin
            busy_tick = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q     <= 16'd0;
            stat_errs_q    <= 16'd0;
            stat_maxwait_q <= 16'd0;
            busy_tot_q     <= 16'd0;
        end else begin
            if (state_q == S_IDLE) begin
                busy_tot_q <= 16'd0;
            end else if (busy_tick && busy_tot_q != 16'hFFFF) begin
                busy_tot_q <= busy_tot_q + 16'd1;
            end

            if (state_q == S_RESP) begin
                if (rsp_err_q == ERR_OK) begin
                    if (stat_ops_q != 16'hFFFF) begin
                        stat_ops_q <= stat_ops_q + 16'd1;
                    end
                end else if (stat_errs_q != 16'hFFFF) begin
                    stat_errs_q <= stat_errs_q + 16'd1;
                end
                if (busy_tot_q > stat_maxwait_q) begin
                    stat_maxwait_q <= busy_tot_q;
                end
            end
        end
    end

    assign stat_ops     = stat_ops_q;
    assign stat_errs    = stat_errs_q;
    assign stat_maxwait = stat_maxwait_q;
`endif

endmodule

// File: tb/tb_pq_rd_driver.sv
// ---------------------------------------------------------------------------
// tb_pq_rd_driver
//   Self-checking bench for pq_rd_driver. The bench plays both the command
//   sequencer and a simple PQ that holds busy for a chosen number of cycles
//   before the command and after each strobe. Expected response cycle, error
//   code, head value and strobe timing come from a timing model derived from
//   the operation rules. Built with TIMEOUT=8, MIN_WAIT=1.
// ---------------------------------------------------------------------------
module tb_pq_rd_driver;
    localparam int KV_W     = 16;
    localparam int MIN_WAIT = 1;
    localparam int TIMEOUT  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pq_rd_driver_if #(.KV_W(KV_W)) bus ();

`ifdef PQ_DRV_STATS_EN
    logic [15:0] stat_ops, stat_errs, stat_maxwait;
    int m_ops  = 0;
    int m_errs = 0;
    int m_maxw = 0;
`endif

    pq_rd_driver #(
        .KV_W(KV_W), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef PQ_DRV_STATS_EN
        ,
        .stat_ops(stat_ops),
        .stat_errs(stat_errs),
        .stat_maxwait(stat_maxwait)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Timing/result model. Cycle 1 is the first cycle after the accepting
    // edge. p = cycles busy is high from cycle 1, b = busy cycles after strobe.
    task automatic model(input logic [1:0] op, input bit empty, input int p,
                         input int b, output int exp_rsp, output logic [1:0] exp_err,
                         output int exp_strobe, output int busy_waits);
        int issue;
        exp_strobe = 0;
        busy_waits = 0;
        if (op == 2'b11) begin
            exp_rsp = 2; exp_err = 2'b11;
        end else if (op == 2'b01 && empty) begin
            exp_rsp = 2; exp_err = 2'b01;
        end else if (p - 1 >= TIMEOUT) begin
            exp_rsp = TIMEOUT + 2; exp_err = 2'b10; busy_waits = TIMEOUT;
        end else begin
            issue      = (p == 0) ? 2 : p + 2;
            busy_waits = (p > 0) ? p - 1 : 0;
            if (op == 2'b00) begin
                exp_rsp = issue + 1; exp_err = 2'b00;
            end else begin
                exp_strobe = issue;
                if (b >= TIMEOUT) begin
                    exp_rsp = issue + 1 + TIMEOUT; exp_err = 2'b10;
                    busy_waits += TIMEOUT;
                end else begin
                    exp_rsp = issue + 2 + b; exp_err = 2'b00;
                    busy_waits += b;
                end
            end
        end
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [15:0] kv,
                           input logic [15:0] kvo, input bit empty,
                           input int p, input int b, input string tag);
        int exp_rsp, exp_strobe, bw;
        logic [1:0] exp_err;
        int c, s, got_rsp, n_deq, n_rep;
        logic [15:0] got_kv, kvi_at;
        logic [1:0]  got_err;
        bit busy_strobe, both, ready_seen;

        model(op, empty, p, b, exp_rsp, exp_err, exp_strobe, bw);
        bus.pq_kvo   = kvo;
        bus.pq_empty = empty;
        bus.pq_full  = 1'($urandom_range(0, 1));
        bus.pq_busy  = 1'b0;

        c = 0;
        while (bus.cmd_ready !== 1'b1 && c < 20) begin
            @(posedge clk); #1; c++;
        end
        if (c >= 20) begin
            vectors++; miscompares++;
            $display("FAIL %s ready: cmd_ready=%b, expected 1", tag, bus.cmd_ready);
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_kv    = kv;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_kv    = 16'($urandom);

        c = 1; s = 0; got_rsp = 0; n_deq = 0; n_rep = 0;
        busy_strobe = 0; both = 0; ready_seen = 0;
        got_kv = '0; got_err = '0; kvi_at = '0;
        while (got_rsp == 0 && c <= 60) begin
            bus.pq_busy = (c <= p) || (s > 0 && c > s && c <= s + b);
            @(negedge clk);
            if (bus.pq_deq) n_deq++;
            if (bus.pq_replace) n_rep++;
            if (bus.pq_deq || bus.pq_replace) begin
                if (s == 0) s = c;
                kvi_at = bus.pq_kvi;
                if (bus.pq_busy) busy_strobe = 1;
                if (bus.pq_deq && bus.pq_replace) both = 1;
            end
            if (bus.cmd_ready) ready_seen = 1;
            if (bus.rsp_valid) begin
                got_rsp = c; got_kv = bus.rsp_kv; got_err = bus.rsp_err;
            end
            @(posedge clk); #1; c++;
        end
        bus.pq_busy = 1'b0;

        vectors++;
        if (got_rsp !== exp_rsp) begin
            miscompares++;
            $display("FAIL %s latency: rsp_valid at cycle %0d, expected %0d", tag, got_rsp, exp_rsp);
        end
        vectors++;
        if (got_err !== exp_err) begin
            miscompares++;
            $display("FAIL %s rsp_err: got %b, expected %b", tag, got_err, exp_err);
        end
        if (exp_err == 2'b00) begin
            vectors++;
            if (got_kv !== kvo) begin
                miscompares++;
                $display("FAIL %s rsp_kv: got %h, expected %h", tag, got_kv, kvo);
            end
        end
        vectors++;
        if (n_deq !== ((op == 2'b01 && exp_strobe != 0) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL %s deq_count: got %0d pulses, expected %0d", tag, n_deq,
                     (op == 2'b01 && exp_strobe != 0) ? 1 : 0);
        end
        vectors++;
        if (n_rep !== ((op == 2'b10 && exp_strobe != 0) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL %s replace_count: got %0d pulses, expected %0d", tag, n_rep,
                     (op == 2'b10 && exp_strobe != 0) ? 1 : 0);
        end
        vectors++;
        if (s !== exp_strobe) begin
            miscompares++;
            $display("FAIL %s strobe_cycle: got %0d, expected %0d", tag, s, exp_strobe);
        end
        if (op == 2'b10 && exp_strobe != 0) begin
            vectors++;
            if (kvi_at !== kv) begin
                miscompares++;
                $display("FAIL %s pq_kvi: got %h, expected %h", tag, kvi_at, kv);
            end
        end
        vectors++;
        if (busy_strobe || both) begin
            miscompares++;
            $display("FAIL %s strobe_rules: busy_overlap=%0d both=%0d, expected 0 0", tag, busy_strobe, both);
        end
        vectors++;
        if (ready_seen) begin
            miscompares++;
            $display("FAIL %s ready_during_op: cmd_ready seen high, expected low", tag);
        end

        @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_resp: cmd_ready=%b rsp_valid=%b, expected 1 0", tag, bus.cmd_ready, bus.rsp_valid);
        end
`ifdef PQ_DRV_STATS_EN
        if (exp_err == 2'b00) m_ops++; else m_errs++;
        if (bw > m_maxw) m_maxw = bw;
        vectors++;
        if (stat_ops !== 16'(m_ops) || stat_errs !== 16'(m_errs) || stat_maxwait !== 16'(m_maxw)) begin
            miscompares++;
            $display("FAIL %s stats: got ops=%0d errs=%0d maxw=%0d, expected %0d %0d %0d",
                     tag, stat_ops, stat_errs, stat_maxwait, m_ops, m_errs, m_maxw);
        end
`endif
        $display("txn %s: op=%b kv=%h p=%0d b=%0d rsp_cycle=%0d err=%b kv_out=%h",
                 tag, op, kv, p, b, got_rsp, got_err, got_kv);
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_kv !== 16'h0 ||
            bus.rsp_err !== 2'b00 || bus.pq_kvi !== 16'h0 || bus.pq_replace !== 1'b0 ||
            bus.pq_deq !== 1'b0) begin
            miscompares++;
            $display("FAIL %s outputs: ready=%b valid=%b kv=%h err=%b kvi=%h rep=%b deq=%b, expected all 0",
                     tag, bus.cmd_ready, bus.rsp_valid, bus.rsp_kv, bus.rsp_err,
                     bus.pq_kvi, bus.pq_replace, bus.pq_deq);
        end
        vectors++;
        if (bus.pq_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL %s pq_rst: got %b, expected 1", tag, bus.pq_rst);
        end
`ifdef PQ_DRV_STATS_EN
        m_ops = 0; m_errs = 0; m_maxw = 0;
        vectors++;
        if (stat_ops !== 16'h0 || stat_errs !== 16'h0 || stat_maxwait !== 16'h0) begin
            miscompares++;
            $display("FAIL %s stats_reset: got %0d %0d %0d, expected 0 0 0", tag, stat_ops, stat_errs, stat_maxwait);
        end
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.pq_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL reset pq_rst_release: got %b, expected 0", bus.pq_rst);
        end
        @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset ready_after: got %b, expected 1", bus.cmd_ready);
        end
        $display("txn reset: done");
    endtask

    task automatic test_peek;
        run_txn(2'b00, 16'hFFFF, 16'h1234, 1'b0, 0, 0, "peek");
    endtask

    task automatic test_deq_empty;
        run_txn(2'b01, 16'h0000, 16'h4321, 1'b1, 0, 0, "deq_empty");
    endtask

    task automatic test_replace_busy;
        run_txn(2'b10, 16'h00A5, 16'h0011, 1'b0, 0, 4, "replace_busy");
    endtask

    task automatic test_timeout;
        run_txn(2'b10, 16'h5A5A, 16'h0022, 1'b0, 1000, 0, "timeout_rdy");
        run_txn(2'b01, 16'h0000, 16'h0033, 1'b0, 0, TIMEOUT, "timeout_done");
        run_txn(2'b01, 16'h0000, 16'h0044, 1'b0, TIMEOUT, TIMEOUT - 1, "edge_no_timeout");
    endtask

    task automatic test_bad_op;
        run_txn(2'b11, 16'h1111, 16'h0055, 1'b0, 0, 0, "bad_op");
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            int p, b;
            op = 2'($urandom_range(0, 3));
            p  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 0;
            b  = int'($urandom_range(0, 9));
            run_txn(op, 16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
                    p, b, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid;
        int c, n_ev;
        bit seen;
        bus.pq_empty = 1'b0;
        bus.pq_busy  = 1'b0;
        bus.pq_kvo   = 16'h7777;
        c = 0;
        while (bus.cmd_ready !== 1'b1 && c < 20) begin
            @(posedge clk); #1; c++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_kv    = 16'hBEEF;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        seen = 0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            if (bus.pq_replace) seen = 1;
            @(posedge clk); #1; c++;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL reset_mid strobe: no replace strobe within %0d cycles, expected one", c);
        end
        bus.pq_busy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_mid");
        rst = 1'b0;
        bus.pq_busy = 1'b0;
        n_ev = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.pq_replace || bus.pq_deq) n_ev++;
        end
        vectors++;
        if (n_ev != 0) begin
            miscompares++;
            $display("FAIL reset_mid aftermath: %0d rsp/strobe cycles seen, expected 0", n_ev);
        end
        $display("txn reset_mid: aborted replace, events after reset=%0d", n_ev);
        run_txn(2'b00, 16'h0000, 16'hC0DE, 1'b0, 0, 0, "peek_after_reset");
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_kv    = '0;
        bus.pq_full   = 1'b0;
        bus.pq_busy   = 1'b0;
        bus.pq_empty  = 1'b0;
        bus.pq_kvo    = '0;

        test_reset();
        test_peek();
        test_deq_empty();
        test_replace_busy();
        test_timeout();
        test_bad_op();
        test_random();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global guard so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pq_rd_driver.md
Name: pq_rd_driver

Overview:
- Initiator-side controller for the priority-queue read/replace interface. It drives the same signals the PQ device receives: kvi, replace, deq and rst, and it samples full, busy, empty and kvo.
- It accepts single commands over a valid/ready port and issues each one to the PQ as a one-cycle pulse. It then waits for the PQ to finish and returns the resulting key/value on a response port.
- It sits between the board-level pushbutton/switch logic (or a bench sequencer) and the PQ instance. This lets the top level drive the PQ without hand-built pulse logic.

Parameters:
- KV_W, 16, width of the key/value word (matches kv_t).
- MIN_WAIT, 1, cycles after an issue pulse before busy is sampled for completion (1..15).
- TIMEOUT, 255, maximum cycles busy may stay high before an operation is aborted with an error (1..65535).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  a command is presented
- cmd_ready  output  1  driver can accept a command this cycle
- cmd_op  input  2  00 PEEK, 01 DEQ, 10 REPLACE, 11 reserved
- cmd_kv  input  KV_W  key/value for REPLACE; ignored otherwise
- rsp_valid  output  1  one-cycle pulse; response fields are valid
- rsp_kv  output  KV_W  head of the queue sampled before the operation
- rsp_err  output  2  00 ok, 01 deq-on-empty, 10 timeout, 11 bad op
- pq_rst  output  1  reset to the PQ; equals rst
- pq_kvi  output  KV_W  value driven to the PQ
- pq_replace  output  1  one-cycle replace strobe
- pq_deq  output  1  one-cycle dequeue strobe
- pq_full  input  1  PQ full
- pq_busy  input  1  PQ busy
- pq_empty  input  1  PQ empty
- pq_kvo  input  KV_W  PQ head output

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) forces state IDLE, and all of the following to 0:
  - cmd_ready, rsp_valid, rsp_kv, rsp_err
  - pq_kvi, pq_replace, pq_deq
  - wait and timeout counters
- pq_rst = rst combinationally.
- Reset mid-operation aborts the operation with no response. Any strobe already in flight is not repeated.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op and kv and go to CHECK. cmd_ready falls in the next cycle.
  - Exactly one command is accepted per handshake.
- CHECK (one cycle):
  - op=11: rsp_err=11, go to RESP.
  - op=01 and pq_empty=1: rsp_err=01, go to RESP. No strobe is issued.
  - pq_busy=1: go to WAIT_RDY.
  - Otherwise: go to ISSUE.
- WAIT_RDY:
  - Remain here while pq_busy=1, counting cycles.
  - If the count reaches TIMEOUT: rsp_err=10, go to RESP.
  - On busy=0, re-evaluate the empty check for DEQ, then go to ISSUE.
- ISSUE (one cycle):
  - Capture rsp_kv <= pq_kvo.
  - Assert the strobe for exactly one cycle: pq_deq for DEQ, pq_replace for REPLACE.
  - PEEK asserts no strobe and goes directly to RESP with err 00.
  - pq_kvi is driven with the latched kv from ISSUE onward. It holds until the next REPLACE is issued.
- WAIT_DONE:
  - Count MIN_WAIT cycles, then remain while pq_busy=1.
  - On busy=0: rsp_err=00, go to RESP.
  - Timeout counting restarts at entry. Reaching TIMEOUT sets rsp_err=10 and goes to RESP.
- RESP (one cycle): rsp_valid=1, then return to IDLE.
  - rsp_kv and rsp_err hold until the next RESP.
- Latency, with PQ idle: accept-to-rsp_valid = 3 + MIN_WAIT + (cycles busy is high).
  - Example: PEEK has a fixed latency of 3 cycles, with rsp_valid in the 3rd cycle after acceptance.
- REPLACE on full or empty is always legal; the PQ performs a simultaneous deq+enq.
- Strobes are never asserted in the same cycle as each other. Strobes are never asserted while pq_busy=1.
- Counters saturate and never wrap.

Optional Feature:
- Macro PQ_DRV_STATS_EN.
- When defined, the block adds outputs:
  - stat_ops (16 bits): count of completed ok operations
  - stat_errs (16 bits): count of error responses
  - stat_maxwait (16 bits): largest total busy-wait count seen in any single operation
- All three reset to 0 and saturate at 16'hFFFF. They are updated in the RESP cycle.
- When undefined, these ports and their registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then PEEK with pq_kvo=16'h1234 and the PQ idle -> rsp_valid 3 cycles after acceptance, rsp_kv=16'h1234, rsp_err=00, no strobes.
- DEQ with pq_empty=1 -> rsp_err=01, pq_deq never asserted, cmd_ready returns high.
- REPLACE kv=16'h00A5 with pq_busy going high for 4 cycles after the strobe -> pq_replace high for exactly 1 cycle, pq_kvi=16'h00A5, rsp_valid after busy falls, rsp_err=00.
- pq_busy held high with TIMEOUT=8 -> rsp_err=10 after 8 wait cycles, no strobe issued.
- cmd_op=11 -> rsp_err=11; with PQ_DRV_STATS_EN, stat_errs increments to 1.
- rst asserted during WAIT_DONE -> next cycle all outputs are 0, state is IDLE, no rsp_valid, and a following PEEK completes normally.
